// File: rtl/ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ifu_fetch                                                    |
// | Description : Multi-cycle instruction fetch unit, one instruction in       |
// |               flight, fetches over valid/ready imem, hands off to decode.  |
// | Options     : IFU_ALIGN_CHECK_EN enables sticky misaligned-PC fault.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        commit_valid,
  input  logic [31:0] next_pc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_fault;
  logic        w_misaligned;
  logic [31:0] w_pc_nxt;

  // PC_STEP is reserved for performance reporting; the EXU always supplies next_pc.
  logic [33:0] w_unused_bits;
  assign w_unused_bits = {next_pc[1:0], 32'(PC_STEP)};

`ifdef IFU_ALIGN_CHECK_EN
  assign w_misaligned = |next_pc[1:0];
  assign w_pc_nxt     = next_pc;
`else
  assign w_misaligned = 1'b0;
  assign w_pc_nxt     = {next_pc[31:2], 2'b00};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ:   if (imem_req_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) w_state_nxt = S_HOLD;
      S_HOLD:  if (inst_ready) w_state_nxt = S_EXEC;
      S_EXEC:  if (commit_valid) w_state_nxt = w_misaligned ? S_FAULT : S_REQ;
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_inst    <= 32'h0;
      r_inst_pc <= 32'h0;
      r_fault   <= 1'b0;
    end else begin
      if (r_state == S_WAIT && imem_rsp_valid) begin
        r_inst    <= imem_rsp_data;
        r_inst_pc <= r_pc;
      end
      // Commit is only honoured once decode has taken the instruction.
      if (r_state == S_EXEC && commit_valid) begin
        r_pc <= w_pc_nxt;
        if (w_misaligned) begin
          r_fault <= 1'b1;
        end
      end
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_state == S_HOLD);
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign fetch_fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ifu_fetch                                                 |
// | Description : Randomized scoreboard bench for ifu_fetch with memory and    |
// |               decode/EXU models.                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        commit_valid = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        fetch_fault;

  ifu_fetch #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .commit_valid(commit_valid), .next_pc(next_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];

  // environment state
  bit          pending, busy, last_req_fire, last_inst_fire;
  bit          real_commit, use_forced, fault_armed;
  int          rsp_cnt, ex_cnt, consumed;
  int          ready_pct, iready_pct, max_rsp_delay;
  logic [31:0] rsp_addr, last_req_addr, forced_pc, npc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0000_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] fetch_addr(input logic [31:0] p);
`ifdef IFU_ALIGN_CHECK_EN
    return p;
`else
    return p & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          m_req_stall, m_inst_stall, m_real_commit;
  logic [31:0] m_req_addr, m_inst, m_inst_pc, m_a;
  logic [63:0] m_e;

  always @(negedge clk) begin
    if (rst) begin
      m_req_stall   = 1'b0;
      m_inst_stall  = 1'b0;
      m_real_commit = 1'b0;
    end else begin
      if (m_real_commit) check("req_after_commit", {31'h0, imem_req_valid}, 32'h1);
      if (m_req_stall) begin
        check("req_valid_hold", {31'h0, imem_req_valid}, 32'h1);
        check("req_addr_hold", imem_req_addr, m_req_addr);
      end
      if (m_inst_stall) begin
        check("inst_valid_hold", {31'h0, inst_valid}, 32'h1);
        check("inst_hold", inst, m_inst);
        check("inst_pc_hold", inst_pc, m_inst_pc);
      end
      if (imem_req_valid && imem_req_ready) begin
        if (exp_addr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: got request addr %08h expected no request", imem_req_addr);
        end else begin
          m_a = exp_addr_q.pop_front();
          check("req_addr", imem_req_addr, m_a);
          exp_inst_q.push_back({mem_word(m_a), m_a});
        end
      end
      if (inst_valid && inst_ready) begin
        if (exp_inst_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_inst: got inst %08h expected no instruction", inst);
        end else begin
          m_e = exp_inst_q.pop_front();
          check("inst", inst, m_e[63:32]);
          check("inst_pc", inst_pc, m_e[31:0]);
        end
      end
      if (!fault_armed) check("fetch_fault_low", {31'h0, fetch_fault}, 32'h0);
      m_req_stall   = imem_req_valid && !imem_req_ready;
      m_req_addr    = imem_req_addr;
      m_inst_stall  = inst_valid && !inst_ready;
      m_inst        = inst;
      m_inst_pc     = inst_pc;
      m_real_commit = real_commit;
    end
  end

  // ---------------- stimulus: memory + decode/EXU models ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (last_req_fire) begin
      pending  = 1'b1;
      rsp_cnt  = $urandom_range(1, max_rsp_delay);
      rsp_addr = last_req_addr;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pending) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(rsp_addr);
        pending        = 1'b0;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      imem_rsp_valid = 1'b1;
    end
    imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    inst_ready     = ($urandom_range(0, 99) < iready_pct);

    if (last_inst_fire) begin
      busy   = 1'b1;
      ex_cnt = $urandom_range(1, 3);
      consumed++;
    end
    commit_valid = 1'b0;
    real_commit  = 1'b0;
    next_pc      = $urandom;
    if (busy) begin
      ex_cnt--;
      if (ex_cnt == 0) begin
        npc          = use_forced ? forced_pc : (RESET_PC + ($urandom_range(0, 255) << 2));
        use_forced   = 1'b0;
        commit_valid = 1'b1;
        next_pc      = npc;
        busy         = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        if (npc[1:0] != 2'b00) begin
          fault_armed = 1'b1;
        end else begin
          real_commit = 1'b1;
          exp_addr_q.push_back(fetch_addr(npc));
        end
`else
        real_commit = 1'b1;
        exp_addr_q.push_back(fetch_addr(npc));
`endif
      end
    end else if ($urandom_range(0, 5) == 0) begin
      commit_valid = 1'b1;
    end
    last_req_fire  = imem_req_valid && imem_req_ready;
    last_req_addr  = imem_req_addr;
    last_inst_fire = inst_valid && inst_ready;
  endtask

  task automatic reset_dut();
    rst            = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = $urandom;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    commit_valid   = 1'b0;
    real_commit    = 1'b0;
    #1;
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_fetch_fault", {31'h0, fetch_fault}, 32'h0);
    exp_addr_q.delete();
    exp_inst_q.delete();
    pending        = 1'b0;
    busy           = 1'b0;
    last_req_fire  = 1'b0;
    last_inst_fire = 1'b0;
    fault_armed    = 1'b0;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_req_ready = 1'b1;
    exp_addr_q.push_back(RESET_PC);
    check("idle_req_valid", {31'h0, imem_req_valid}, 32'h0);
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    check("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("first_req_addr", imem_req_addr, RESET_PC);
    last_req_fire  = imem_req_valid && imem_req_ready;
    last_req_addr  = imem_req_addr;
    last_inst_fire = 1'b0;
  endtask

  task automatic wait_consumed(input string name, input int target);
    int n;
    n = 0;
    while (consumed < target && n < 500) begin
      step();
      n++;
    end
    if (consumed < target) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: got %0d consumed expected %0d", name, consumed, target);
    end
  endtask

  initial begin
    int n;
    consumed      = 0;
    use_forced    = 1'b0;
    ready_pct     = 100;
    iready_pct    = 100;
    max_rsp_delay = 1;
    #2;
    reset_dut();
    wait_consumed("first", 1);

    // randomized traffic with backpressure and variable latency
    ready_pct     = 55;
    iready_pct    = 45;
    max_rsp_delay = 3;
    wait_consumed("random1", consumed + 30);

    forced_pc  = 32'h8000_0010;
    use_forced = 1'b1;
    wait_consumed("commit_0010", consumed + 2);

    // abort a fetch while the response is outstanding
    n = 0;
    while (!pending && n < 500) begin
      step();
      n++;
    end
    if (!pending) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_wait_state: got no WAIT state expected one");
    end
    reset_dut();
    wait_consumed("after_reset", consumed + 20);

    forced_pc  = 32'h8000_0012;
    use_forced = 1'b1;
`ifdef IFU_ALIGN_CHECK_EN
    n = 0;
    while (!fault_armed && n < 500) begin
      step();
      n++;
    end
    if (!fault_armed) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_fault_commit: got no commit expected one");
    end
    repeat (10) begin
      step();
      check("fault_sticky", {31'h0, fetch_fault}, 32'h1);
      check("fault_no_req", {31'h0, imem_req_valid}, 32'h0);
      check("fault_no_inst", {31'h0, inst_valid}, 32'h0);
      check("fault_pc", imem_req_addr, 32'h8000_0012);
    end
`else
    wait_consumed("misaligned", consumed + 2);
`endif
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
